regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port register file for the CPU datapath.
//  - NUM_RD asynchronous read ports; two synchronous write ports:
//    - A: ALU writeback.
//    - B: long-latency/load writeback.
//  - Same-cycle write-to-read bypass; register 0 hardwired to zero.
//  - Per-register busy scoreboard for hazard detection.
//  - Reset runs a sequential clear sweep.
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   address width; DEPTH = 2**ADDR_W entries
//  NUM_RD    2   number of read ports (1..4)
//  ZERO_REG  1   1: entry 0 reads 0, ignores writes, never busy; 0: entry 0 is ordinary
// PORTS
//  clk            in   1               clock, all state updates on posedge
//  rst            in   1               reset, synchronous, active-high
//  rd_addr        in   NUM_RD*ADDR_W   read addresses, port i = bits [i*ADDR_W +: ADDR_W]
//  rd_data        out  NUM_RD*DATA_W   read data, port i = bits [i*DATA_W +: DATA_W]
//  rd_busy        out  NUM_RD          scoreboard busy bit of each read address
//  rd_perr        out  NUM_RD          parity error on each read port (see CONFIGURATION)
//  wa_en          in   1               write port A enable
//  wa_addr        in   ADDR_W          write port A address
//  wa_data        in   DATA_W          write port A data
//  wb_en          in   1               write port B enable; also clears busy of wb_addr
//  wb_addr        in   ADDR_W          write port B address
//  wb_data        in   DATA_W          write port B data
//  busy_set       in   1               mark busy_addr busy (long-latency op issued)
//  busy_addr      in   ADDR_W          scoreboard set address
//  ready          out  1               1 = clear sweep done, file usable
// BEHAVIOUR
//  - FSM states: CLEAR, RUN.
//  - rst=1 at a posedge: state<=CLEAR, clr_cnt<=0, all busy bits<=0.
//    - Applies from any state, including mid-sweep: the sweep restarts at 0.
//  - CLEAR: each cycle writes 0 to entry clr_cnt and increments clr_cnt.
//    - After entry DEPTH-1 is cleared: state<=RUN.
//    - The sweep takes DEPTH cycles after rst deasserts.
//  - ready = (state==RUN); ready is 0 from the cycle after rst is sampled.
//  - In CLEAR: wa_en, wb_en and busy_set are ignored; rd_data=0, rd_busy=0, rd_perr=0.
//  - Reads are combinational, 0-cycle latency:
//    - If wb_en && wb_addr==rd_addr: rd_data=wb_data.
//    - Else if wa_en && wa_addr==rd_addr: rd_data=wa_data.
//    - Else: rd_data = stored value.
//  - Writes commit at posedge in RUN.
//    - Both ports writing the same address: port B wins.
//  - ZERO_REG=1: writes and busy_set to address 0 are dropped.
//    - Reads of address 0 return 0 with rd_busy=0, bypass included.
//  - Scoreboard, one bit per entry:
//    - busy_set sets busy[busy_addr].
//    - wb_en clears busy[wb_addr]; port A never clears busy.
//    - Set and clear of the same address in the same cycle: set wins (new op issued).
//    - rd_busy = busy[rd_addr] with bypass:
//      - 0 if wb_en clears that address this cycle and busy_set does not target it.
//      - busy_set targeting an address does not raise rd_busy until the next cycle.
//  - Widths: addresses are used unsigned, full ADDR_W range; data is stored verbatim.
// CONFIGURATION
//  REGFILE_PARITY_EN defined:
//    - Each entry stores an extra even-parity bit computed from the written data.
//    - rd_perr[i] = stored parity != ^stored data for non-bypassed reads; 0 when bypassed.
//    - The clear sweep writes parity 0.
//    - Benches inject errors by hierarchical force on the parity array.
//  REGFILE_PARITY_EN undefined:
//    - No parity storage; rd_perr is tied to 0.
// TESTING
//  1. rst 1 cycle, then deassert -> ready=0 for 32 cycles, 1 on cycle 33;
//     every rd_data=0 afterwards.
//  2. rst at sweep cycle 10 -> clr_cnt restarts, ready rises 32 cycles after the
//     second rst; a write attempted mid-sweep (addr 5 = 0xDEAD) -> later read 0.
//  3. wa 3<=0x11 and wb 3<=0x22 same cycle with rd_addr[0]=3 -> rd_data=0x22 same cycle
//     and next cycle; wa 0<=0xFF -> read of 0 returns 0.
//  4. busy_set 7 -> rd_busy=1 next cycle; wb_en 7 with busy_set 7 same cycle ->
//     still 1; wb_en 7 alone -> rd_busy=0 in that cycle.
//  5. NUM_RD=3, DATA_W=64: write 0x0123456789ABCDEF to 9 -> all three ports
//     reading 9 match.
//  6. With REGFILE_PARITY_EN: write 0xA5 to 4, force parity bit flip ->
//     rd_perr=1 on port reading 4; without the macro rd_perr=0.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD async read ports, two sync write ports,
// write-to-read bypass, busy scoreboard, reset clear sweep. Optional parity: REGFILE_PARITY_EN.
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [NUM_RD-1:0]        rd_perr,
  input  logic                     wa_en,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     busy_set,
  input  logic [ADDR_W-1:0]        busy_addr,
  output logic                     ready
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy, busy_nxt;
  logic              run;
  logic              wa_ok, wb_ok, bs_ok;
`ifdef REGFILE_PARITY_EN
  logic [DEPTH-1:0]  par_mem;
`endif

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  always_comb begin
    run   = (state == RUN);
    wa_ok = run && !rst && wa_en && !is_zero(wa_addr);
    wb_ok = run && !rst && wb_en && !is_zero(wb_addr);
    bs_ok = run && !rst && busy_set && !is_zero(busy_addr);
    ready = run;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == CLEAR && clr_cnt == '1) state_nxt = RUN;
  end

  always_ff @(posedge clk) begin
    if (rst)                 clr_cnt <= '0;
    else if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
  end

  // Storage has no reset of its own; the sweep clears one entry per cycle.
  // Port B is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else begin
      if (wa_ok) mem[wa_addr] <= wa_data;
      if (wb_ok) mem[wb_addr] <= wb_data;
    end
  end

`ifdef REGFILE_PARITY_EN
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      par_mem[clr_cnt] <= 1'b0;
    end else begin
      if (wa_ok) par_mem[wa_addr] <= ^wa_data;
      if (wb_ok) par_mem[wb_addr] <= ^wb_data;
    end
  end
`endif

  // Set is applied after clear so a newly issued op keeps its register busy.
  always_comb begin
    busy_nxt = busy;
    if (wb_ok) busy_nxt[wb_addr]   = 1'b0;
    if (bs_ok) busy_nxt[busy_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    rd_perr = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      logic [ADDR_W-1:0] a;
      a = rd_addr[i*ADDR_W +: ADDR_W];
      if (run && !is_zero(a)) begin
        if (wb_en && wb_addr == a) begin
          rd_data[i*DATA_W +: DATA_W] = wb_data;
        end else if (wa_en && wa_addr == a) begin
          rd_data[i*DATA_W +: DATA_W] = wa_data;
        end else begin
          rd_data[i*DATA_W +: DATA_W] = mem[a];
`ifdef REGFILE_PARITY_EN
          rd_perr[i] = par_mem[a] != (^mem[a]);
`endif
        end
        rd_busy[i] = busy[a] && !(wb_en && wb_addr == a && !(busy_set && busy_addr == a));
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (3 read ports, 64-bit data, zero register on).
module tb_regfile_mp;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy, rd_perr;
  logic             wa_en = 1'b0, wb_en = 1'b0, busy_set = 1'b0;
  logic [AW-1:0]    wa_addr = '0, wb_addr = '0, busy_addr = '0;
  logic [DW-1:0]    wa_data = '0, wb_data = '0;
  logic             ready;

  int unsigned total = 0;
  int unsigned passed = 0;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .rd_perr(rd_perr), .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .busy_set(busy_set),
    .busy_addr(busy_addr), .ready(ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wa_en;
    logic [AW-1:0] wa_addr;
    logic [DW-1:0] wa_data;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          bs;
    logic [AW-1:0] bs_addr;
    logic [AW-1:0] ra0, ra1, ra2;
    logic [DW-1:0] e0, e1, e2;
    logic [NR-1:0] eb;
  } vec_t;

  localparam logic [DW-1:0] C = 64'h0123456789ABCDEF;
  localparam logic [DW-1:0] F = 64'hFFFFFFFFFFFFFFFF;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle();
    wa_en = 1'b0; wb_en = 1'b0; busy_set = 1'b0;
  endtask

  // Reset for one cycle, then count cycles until ready rises (bounded).
  task automatic do_reset(input string name);
    int unsigned cnt;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1 chk({name, "_ready_low"}, 64'(ready), 64'd0);
    cnt = 0;
    while (!ready && cnt < 100) begin
      @(negedge clk); cnt++;
    end
    chk({name, "_sweep_len"}, 64'(cnt), 64'd32);
  endtask

  initial begin
    vecs[0]  = '{1, 3, 'h11, 1, 3, 'h22,  0, 0,  3, 3, 0,  'h22, 'h22, 0, 3'b000};
    vecs[1]  = '{0, 0, 0,    0, 0, 0,     0, 0,  3, 0, 1,  'h22, 0, 0,    3'b000};
    vecs[2]  = '{1, 0, 'hFF, 0, 0, 0,     0, 0,  0, 3, 0,  0, 'h22, 0,    3'b000};
    vecs[3]  = '{1, 5, 'h55, 0, 0, 0,     0, 0,  0, 5, 3,  0, 'h55, 'h22, 3'b000};
    vecs[4]  = '{0, 0, 0,    1, 9, C,     1, 7,  7, 9, 5,  0, C, 'h55,    3'b000};
    vecs[5]  = '{0, 0, 0,    0, 0, 0,     0, 0,  7, 9, 9,  0, C, C,       3'b001};
    vecs[6]  = '{0, 0, 0,    1, 7, 'h77,  1, 7,  7, 7, 9,  'h77, 'h77, C, 3'b011};
    vecs[7]  = '{0, 0, 0,    0, 0, 0,     0, 0,  7, 9, 9,  'h77, C, C,    3'b001};
    vecs[8]  = '{0, 0, 0,    1, 7, 'h78,  0, 0,  7, 7, 7,  'h78, 'h78, 'h78, 3'b000};
    vecs[9]  = '{0, 0, 0,    0, 0, 0,     0, 0,  7, 9, 9,  'h78, C, C,    3'b000};
    vecs[10] = '{0, 0, 0,    0, 0, 0,     1, 0,  0, 0, 0,  0, 0, 0,       3'b000};
    vecs[11] = '{0, 0, 0,    0, 0, 0,     0, 0,  0, 0, 0,  0, 0, 0,       3'b000};
    vecs[12] = '{1, 31, F,   1, 30, 'h3030, 0, 0, 31, 30, 31, F, 'h3030, F, 3'b000};
    vecs[13] = '{0, 0, 0,    0, 0, 0,     0, 0,  31, 30, 1, F, 'h3030, 0, 3'b000};
    vecs[14] = '{1, 12, 'hAAAA, 1, 12, 'hBBBB, 1, 12, 12, 12, 12, 'hBBBB, 'hBBBB, 'hBBBB, 3'b000};
    vecs[15] = '{0, 0, 0,    0, 0, 0,     0, 0,  12, 12, 31, 'hBBBB, 'hBBBB, F, 3'b011};

    // Reset and sweep length, then every entry reads zero.
    do_reset("rst1");
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      rd_addr = {5'd0, 5'd0, 5'(a)};
      #1 chk($sformatf("clear_rd%0d", a), rd_data[DW-1:0], 64'd0);
    end

    // Mid-sweep restart; writes and busy_set during the sweep are ignored.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      wa_en = 1'b1; wa_addr = 5'd5; wa_data = 64'hDEAD;
      busy_set = 1'b1; busy_addr = 5'd5;
      rd_addr = {5'd5, 5'd5, 5'd5};
      #1;
      if (c == 9) begin
        chk("clear_bypass_data", rd_data[DW-1:0], 64'd0);
        chk("clear_busy", 64'(rd_busy), 64'd0);
      end
    end
    idle();
    do_reset("rst2");
    @(negedge clk);
    rd_addr = {5'd5, 5'd5, 5'd5};
    #1 chk("midsweep_write_dropped", rd_data[DW-1:0], 64'd0);
    chk("midsweep_busy_dropped", 64'(rd_busy), 64'd0);

    // Directed vector table.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      wa_en = vecs[i].wa_en; wa_addr = vecs[i].wa_addr; wa_data = vecs[i].wa_data;
      wb_en = vecs[i].wb_en; wb_addr = vecs[i].wb_addr; wb_data = vecs[i].wb_data;
      busy_set = vecs[i].bs; busy_addr = vecs[i].bs_addr;
      rd_addr = {vecs[i].ra2, vecs[i].ra1, vecs[i].ra0};
      #1;
      chk($sformatf("v%0d_rd0", i), rd_data[0*DW +: DW], vecs[i].e0);
      chk($sformatf("v%0d_rd1", i), rd_data[1*DW +: DW], vecs[i].e1);
      chk($sformatf("v%0d_rd2", i), rd_data[2*DW +: DW], vecs[i].e2);
      chk($sformatf("v%0d_busy", i), 64'(rd_busy), 64'(vecs[i].eb));
      chk($sformatf("v%0d_perr", i), 64'(rd_perr), 64'd0);
    end
    idle();

    // Parity error injection on entry 4.
    @(negedge clk);
    wa_en = 1'b1; wa_addr = 5'd4; wa_data = 64'hA5;
    @(negedge clk);
    idle();
`ifdef REGFILE_PARITY_EN
    begin
      logic [31:0] pv;
      pv = dut.par_mem;
      pv[4] = ~pv[4];
      force dut.par_mem = pv;
      rd_addr = {5'd3, 5'd4, 5'd4};
      #1 chk("perr_flip", 64'(rd_perr), 64'b011);
      chk("perr_data", rd_data[DW-1:0], 64'hA5);
      @(negedge clk);
      wb_en = 1'b1; wb_addr = 5'd4; wb_data = 64'h1;
      #1 chk("perr_bypassed", 64'(rd_perr), 64'b000);
      release dut.par_mem;
      idle();
    end
`else
    rd_addr = {5'd3, 5'd4, 5'd4};
    #1 chk("perr_off", 64'(rd_perr), 64'd0);
    chk("perr_data", rd_data[DW-1:0], 64'hA5);
`endif

    // Reset from RUN clears the scoreboard and restarts the sweep.
    @(negedge clk);
    rd_addr = {5'd12, 5'd12, 5'd12};
    #1 chk("pre_rst_busy12", 64'(rd_busy), 64'b111);
    do_reset("rst3");
    @(negedge clk);
    rd_addr = {5'd12, 5'd31, 5'd12};
    #1 chk("post_rst_busy", 64'(rd_busy), 64'd0);
    chk("post_rst_data12", rd_data[DW-1:0], 64'd0);
    chk("post_rst_data31", rd_data[DW +: DW], 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
